// File: rtl/roi_pixel_packer.sv
// ROI pixel packer: packs four 8-bit ROI pixels per 32-bit word, tags SOF/EOL,
// and buffers words in a FWFT FIFO toward a stream master. The FIFO drops and counts words when full.

module roi_byte_lane #(
  parameter int W = 8
) (
  input  logic         pixclk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge pixclk) begin
    if (reset)   q <= '0;
    else if (ld) q <= d;
  end
endmodule

module roi_pixel_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                          pixclk,
  input  logic                          reset,
  input  logic                          capture_en,
  input  logic                          frame_begin,
  input  logic                          frame_end,
  input  logic                          line_state,
  input  logic [7:0]                    din,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tuser,
  output logic                          m_tlast,
  output logic                          frame_active,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int CW        = $clog2(NUM_LANES);
  localparam int AW        = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic          prev_ls, sof_pend;
  logic          start, pix, flush, stage;

  logic [NUM_LANES-1:0][LANE_W-1:0] lane_q, stage_word;
  logic [NUM_LANES-1:0]             lane_ld;

  logic        stg_vld, stg_sof;
  logic [31:0] stg_data;

  word_t       mem [FIFO_DEPTH];
  word_t       rd_word, wr_word;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, rd_en, drop, wr_acc;

  // Frame control; a frame_begin inside ACTIVE restarts the frame and wins over pixel/flush work.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pix       = 1'b0;
    flush     = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_begin && capture_en) begin
          start     = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_begin) begin
          start = 1'b1;
        end else begin
          pix   = line_state;
          flush = !line_state && (cnt != '0) && (prev_ls || frame_end);
          if (frame_end) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stage = (pix && cnt == CW'(NUM_LANES - 1)) || flush;

  // Lane cnt takes din this cycle; lower lanes hold earlier pixels, higher lanes are zero-padded.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_ld[i]    = pix && (cnt == CW'(i));
    assign stage_word[i] = lane_ld[i] ? din : ((cnt > CW'(i)) ? lane_q[i] : '0);
    roi_byte_lane #(.W(LANE_W)) u_lane (
      .pixclk (pixclk),
      .reset  (reset),
      .ld     (lane_ld[i]),
      .d      (din),
      .q      (lane_q[i])
    );
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_ls  <= 1'b0;
      sof_pend <= 1'b0;
      stg_vld  <= 1'b0;
      stg_sof  <= 1'b0;
      stg_data <= '0;
    end else begin
      state   <= state_nxt;
      prev_ls <= line_state;
      stg_vld <= stage;
      if (start || stage) cnt <= '0;
      else if (pix)       cnt <= cnt + 1'b1;
      if (start)      sof_pend <= 1'b1;
      else if (stage) sof_pend <= 1'b0;
      if (stage) begin
        stg_data <= stage_word;
        stg_sof  <= sof_pend;
      end
    end
  end

  // Staged word is written one cycle later; line_state low at that point marks end of line.
  assign wr_word = '{data: stg_data, user: stg_sof, last: ~line_state};
  assign rd_word = mem[rd_ptr[AW-1:0]];

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign m_tvalid   = (fifo_level != '0);
  assign rd_en      = m_tvalid && m_tready;
  assign drop       = stg_vld && full && !rd_en;
  assign wr_acc     = stg_vld && !drop;

  assign m_tdata      = m_tvalid ? rd_word.data : '0;
  assign m_tuser      = m_tvalid && rd_word.user;
  assign m_tlast      = m_tvalid && rd_word.last;
  assign frame_active = (state == ACTIVE);

  always_ff @(posedge pixclk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)  rd_ptr <= rd_ptr + 1'b1;
      if (start)  overflow <= 1'b0;
      if (drop)   overflow <= 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_roi_pixel_packer.sv
// Scoreboard bench for roi_pixel_packer: expected words queued as pixels are driven,
// observed words captured on handshakes and compared per scenario.

module tb_roi_pixel_packer;
  localparam int FIFO_DEPTH = 8;
  localparam int DROP_CNT_W = 16;

  logic        pixclk = 1'b0;
  logic        reset, capture_en, frame_begin, frame_end, line_state, m_tready;
  logic [7:0]  din;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, frame_active, overflow;
  logic [DROP_CNT_W-1:0]         drop_cnt;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  roi_pixel_packer #(.FIFO_DEPTH(FIFO_DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
    .pixclk(pixclk), .reset(reset), .capture_en(capture_en), .frame_begin(frame_begin),
    .frame_end(frame_end), .line_state(line_state), .din(din), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .frame_active(frame_active), .overflow(overflow), .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    obs_cyc[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    k4;
  logic  model_sof;

  always @(posedge pixclk) cyc <= cyc + 1;

  always @(negedge pixclk) begin
    if (!reset && m_tvalid && m_tready) begin
      obs_q.push_back('{data: m_tdata, user: m_tuser, last: m_tlast});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic drive(input logic fb, input logic fe, input logic ls, input logic [7:0] d);
    frame_begin = fb; frame_end = fe; line_state = ls; din = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic start_frame(input logic en);
    capture_en = en;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    capture_en = 1'b0;
    if (en) model_sof = 1'b1;
  endtask

  task automatic end_frame();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  // Drives one ROI line plus 2 blanking cycles; the model queues its packed words.
  task automatic send_line(input logic [7:0] base, input int n, input bit model);
    word_t w;
    int nw;
    k4 = -1;
    for (int i = 0; i < n; i++) begin
      if (i == 3) k4 = cyc;
      drive(1'b0, 1'b0, 1'b1, base + 8'(i));
    end
    idle(2);
    nw = (n + 3) / 4;
    if (model) begin
      for (int j = 0; j < nw; j++) begin
        w.data = '0;
        for (int b = 0; b < 4; b++)
          if (4*j + b < n) w.data[8*b +: 8] = base + 8'(4*j + b);
        w.user = model_sof;
        model_sof = 1'b0;
        w.last = (j == nw - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    @(negedge pixclk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
    total++; if (m_tuser !== 1'b0) begin bad++; $display("FAIL rst_tuser got %b want 0", m_tuser); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL rst_active got %b want 0", frame_active); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got %b want 0", overflow); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); end
    total++; if (fifo_level !== '0) begin bad++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    tick();
    reset = 1'b0;
    clear_sb();
  endtask

  task automatic test_width8();
    int first_k4;
    clear_sb();
    start_frame(1'b1);
    @(negedge pixclk);
    total++; if (frame_active !== 1'b1) begin bad++; $display("FAIL w8_active got %b want 1", frame_active); end
    tick();
    frame_begin = 1'b0;
    send_line(8'h01, 8, 1'b1);
    end_frame();
    idle(6);
    first_k4 = k4;
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL w8_inactive got %b want 0", frame_active); end
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL w8_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL w8_word%0d got %h/%b/%b want %h/%b/%b", i, obs_q[i].data, obs_q[i].user,
                        obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
    end
    if (obs_cyc.size() > 0) begin
      total++;
      if (obs_cyc[0] !== first_k4 + 2) begin
        bad++; $display("FAIL w8_latency got cycle %0d want %0d", obs_cyc[0], first_k4 + 2);
      end
    end
  endtask

  task automatic test_width6();
    clear_sb();
    start_frame(1'b1);
    send_line(8'hA0, 6, 1'b1);
    end_frame();
    idle(6);
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL w6_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL w6_word%0d got %h/%b/%b want %h/%b/%b", i, obs_q[i].data, obs_q[i].user,
                        obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
    end
  endtask

  task automatic test_capture_off();
    clear_sb();
    start_frame(1'b0);
    send_line(8'h10, 8, 1'b0);
    @(negedge pixclk);
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL off_active got %b want 0", frame_active); end
    tick();
    send_line(8'h20, 5, 1'b0);
    end_frame();
    idle(6);
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL off_count got %0d want 0", obs_q.size()); end
    total++; if (fifo_level !== '0) begin bad++; $display("FAIL off_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_overflow();
    clear_sb();
    m_tready = 1'b0;
    start_frame(1'b1);
    send_line(8'h00, 40, 1'b1);
    end_frame();
    idle(3);
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); end
    m_tready = 1'b1;
    idle(12);
    total++; if (obs_q.size() !== 8) begin bad++; $display("FAIL ovf_drain_count got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ovf_word%0d got %h/%b/%b want %h/%b/%b", i, obs_q[i].data, obs_q[i].user,
                        obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
    end
    start_frame(1'b1);
    @(negedge pixclk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b want 0", overflow); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop_keep got %0d want 2", drop_cnt); end
    tick();
    end_frame();
    idle(2);
    clear_sb();
  endtask

  task automatic test_reset_mid();
    clear_sb();
    start_frame(1'b1);
    drive(1'b0, 1'b0, 1'b1, 8'h51);
    drive(1'b0, 1'b0, 1'b1, 8'h52);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'h53);
    @(negedge pixclk);
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL mid_active got %b want 0", frame_active); end
    total++; if ({m_tvalid, m_tuser, m_tlast, overflow} !== 4'b0) begin
      bad++; $display("FAIL mid_flags got %b want 0000", {m_tvalid, m_tuser, m_tlast, overflow});
    end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL mid_drop_cnt got %0d want 0", drop_cnt); end
    reset = 1'b0;
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h54);
    idle(2);
    end_frame();
    idle(6);
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL mid_count got %0d want 0", obs_q.size()); end
    total++; if (fifo_level !== '0) begin bad++; $display("FAIL mid_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    for (int f = 0; f < 2; f++) begin
      start_frame(1'b1);
      send_line(8'h80 + 8'(16*f), 4, 1'b1);
      send_line(8'h88 + 8'(16*f), 4, 1'b1);
      end_frame();
    end
    idle(6);
    total++; if (obs_q.size() !== 4) begin bad++; $display("FAIL b2b_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_word%0d got %h/%b/%b want %h/%b/%b", i, obs_q[i].data, obs_q[i].user,
                        obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
    end
    total++; if (fifo_level !== '0) begin bad++; $display("FAIL b2b_level got %0d want 0", fifo_level); end
  endtask

  initial begin
    reset = 1'b1; capture_en = 1'b0; frame_begin = 1'b0; frame_end = 1'b0;
    line_state = 1'b0; din = 8'h00; m_tready = 1'b1; model_sof = 1'b0;
    test_reset();
    test_width8();
    test_width6();
    test_capture_off();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
